// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-wire parity-framed serial link.
// Imported by both the receiver and the matching transmitter.
package serial_link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } link_state_e;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   MAX_DATA_W = 16;

    // Parity bit a transmitter sends for 'word' (unused upper bits must be zero).
    function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/serial_rx_hold.sv
// One-entry valid/ready holding register between the receiver and its consumer.
// A word arriving while the entry is full and not being drained is dropped.
module serial_rx_hold #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              perr_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              perr_o,
    output logic              overrun_o
);

    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              perr_q;
    logic              overrun_q;
    logic              can_load;

    // A simultaneous handshake frees the entry in the same cycle.
    assign can_load = !valid_q || ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data register is reset too, because rx_data is visible at reset.
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            overrun_q <= load_i && !can_load;
            if (load_i && can_load) begin
                data_q  <= data_i;
                perr_q  <= perr_i;
                valid_q <= 1'b1;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign perr_o    = perr_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_parity_rx.sv
// Receiver for the parity-framed serial link: start, DATA_W data bits (LSB first),
// parity, stop. Completed words are handed to a one-entry holding register.
module serial_parity_rx
    import serial_link_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              din,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic             ODD_BIT  = (PARITY_ODD != 0);

    link_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              acc_q;
    logic              perr_q;
    logic              frame_err_q;
    logic              deliver;

    // Delivery is decoded from the stop-bit sample so the holding register loads on that edge.
    assign deliver = bit_en && (state_q == STOP) && (din == STOP_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            acc_q       <= 1'b0;
            perr_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (bit_en) begin
                case (state_q)
                    IDLE: begin
                        if (din == START_BIT) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                            acc_q   <= 1'b0;
                        end
                    end
                    DATA: begin
                        shift_q[cnt_q] <= din;
                        acc_q          <= acc_q ^ din;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= PARITY;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    PARITY: begin
                        perr_q  <= acc_q ^ din ^ ODD_BIT;
                        state_q <= STOP;
                    end
                    STOP: begin
                        // A low stop bit drops the word; no break detection follows.
                        frame_err_q <= (din != STOP_BIT);
                        state_q     <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

    serial_rx_hold #(
        .DATA_W(DATA_W)
    ) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (deliver),
        .data_i   (shift_q),
        .perr_i   (perr_q),
        .ready_i  (rx_ready),
        .data_o   (rx_data),
        .valid_o  (rx_valid),
        .perr_o   (parity_err),
        .overrun_o(overrun)
    );

endmodule

// File: tb/tb_serial_parity_rx.sv
// Self-checking bench for serial_parity_rx: an 8-bit even-parity instance (A)
// and a 5-bit odd-parity instance (B), with a scoreboard drained on each handshake.
module tb_serial_parity_rx;
    import serial_link_pkg::*;

    typedef struct packed {
        logic [15:0] data;
        logic        perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       en_a = 1'b0, din_a = 1'b1, ready_a = 1'b0;
    logic [7:0] data_a;
    logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;

    logic       en_b = 1'b0, din_b = 1'b1, ready_b = 1'b0;
    logic [4:0] data_b;
    logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    always #5 clk = ~clk;

    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bit_en(en_a), .din(din_a),
        .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
        .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a)
    );

    serial_parity_rx #(.DATA_W(5), .PARITY_ODD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bit_en(en_b), .din(din_b),
        .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b),
        .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b)
    );

    // Scoreboard: a handshake happens on the next rising edge, so compare the accepted word now.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid_a && ready_a) begin
            checks++;
            if (sb_a.size() == 0) begin
                errors++;
                $display("FAIL sb_a_unexpected: got word %0h, expected no word", data_a);
            end else begin
                e = sb_a.pop_front();
                if ({8'h00, data_a} !== e.data || perr_a !== e.perr) begin
                    errors++;
                    $display("FAIL sb_a_word: got %0h/perr %0b, expected %0h/perr %0b",
                             data_a, perr_a, e.data, e.perr);
                end
            end
        end
        if (rst_n && valid_b && ready_b) begin
            checks++;
            if (sb_b.size() == 0) begin
                errors++;
                $display("FAIL sb_b_unexpected: got word %0h, expected no word", data_b);
            end else begin
                e = sb_b.pop_front();
                if ({11'h000, data_b} !== e.data || perr_b !== e.perr) begin
                    errors++;
                    $display("FAIL sb_b_word: got %0h/perr %0b, expected %0h/perr %0b",
                             data_b, perr_b, e.data, e.perr);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // Independent reference: count ones rather than reduce-XOR.
    function automatic logic good_par(input logic [15:0] word, input bit odd);
        return (($countones(word) % 2) == 1) ^ odd;
    endfunction

    function automatic logic exp_perr(input logic [15:0] word, input logic par, input bit odd);
        int s;
        s = $countones(word) + int'(par);
        return ((s % 2) == 1) ^ odd;
    endfunction

    function automatic logic cur_valid(input bit sel);
        return sel ? valid_b : valid_a;
    endfunction

    task automatic set_ready(input bit sel, input logic v);
        if (sel) ready_b = v;
        else     ready_a = v;
    endtask

    task automatic strobe(input bit sel, input logic b);
        if (sel) begin din_b = b; en_b = 1'b1; end
        else     begin din_a = b; en_a = 1'b1; end
        @(posedge clk); #1;
        en_a = 1'b0;
        en_b = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Returns the 1-based strobe index at which rx_valid rose, 0 if it never did.
    task automatic send_frame(input bit sel, input logic [15:0] word, input int w,
                              input logic par, input logic stop, input int period,
                              input bit ready_at_stop, output int valid_at);
        logic [18:0] bits;
        logic        prev;
        int          n;
        n    = w + 3;
        bits = '0;
        bits[0] = START_BIT;
        for (int i = 0; i < w; i++) bits[i+1] = word[i];
        bits[w+1] = par;
        bits[w+2] = stop;
        valid_at  = 0;
        prev      = cur_valid(sel);
        for (int i = 0; i < n; i++) begin
            if (i > 0) idle_cycles(period - 1);
            if (i == n - 1 && ready_at_stop) set_ready(sel, 1'b1);
            strobe(sel, bits[i]);
            if (!prev && cur_valid(sel) && valid_at == 0) valid_at = i + 1;
            prev = cur_valid(sel);
        end
        if (sel) din_b = LINE_IDLE;
        else     din_a = LINE_IDLE;
    endtask

    task automatic consume(input bit sel);
        set_ready(sel, 1'b1);
        @(posedge clk); #1;
        set_ready(sel, 1'b0);
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({data_a, valid_a, perr_a, ferr_a, ovr_a, busy_a} !== 13'h0) begin
            errors++;
            $display("FAIL reset_a: got %0h, expected 0",
                     {data_a, valid_a, perr_a, ferr_a, ovr_a, busy_a});
        end
        checks++;
        if ({data_b, valid_b, perr_b, ferr_b, ovr_b, busy_b} !== 10'h0) begin
            errors++;
            $display("FAIL reset_b: got %0h, expected 0",
                     {data_b, valid_b, perr_b, ferr_b, ovr_b, busy_b});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_basic;
        int va;
        sb_a.push_back('{16'h00A5, exp_perr(16'h00A5, 1'b0, 1'b0)});
        send_frame(1'b0, 16'h00A5, 8, 1'b0, STOP_BIT, 1, 1'b0, va);
        checks++;
        if (va !== 11) begin
            errors++;
            $display("FAIL basic_latency: got strobe %0d, expected 11", va);
        end
        checks++;
        if ({valid_a, data_a, perr_a, busy_a, ferr_a} !== {1'b1, 8'hA5, 3'b000}) begin
            errors++;
            $display("FAIL basic_word: got v%0b d%0h p%0b b%0b f%0b, expected v1 da5 p0 b0 f0",
                     valid_a, data_a, perr_a, busy_a, ferr_a);
        end
        consume(1'b0);
        checks++;
        if (valid_a !== 1'b0 || data_a !== 8'hA5) begin
            errors++;
            $display("FAIL basic_handshake: got v%0b d%0h, expected v0 da5", valid_a, data_a);
        end
    endtask

    task automatic test_errors;
        int va;
        sb_a.push_back('{16'h00A5, exp_perr(16'h00A5, 1'b1, 1'b0)});
        send_frame(1'b0, 16'h00A5, 8, 1'b1, STOP_BIT, 1, 1'b0, va);
        checks++;
        if (valid_a !== 1'b1 || data_a !== 8'hA5 || perr_a !== 1'b1) begin
            errors++;
            $display("FAIL parity_err: got v%0b d%0h p%0b, expected v1 da5 p1", valid_a, data_a, perr_a);
        end
        consume(1'b0);
        send_frame(1'b0, 16'h00A5, 8, 1'b0, 1'b0, 1, 1'b0, va);
        checks++;
        if (ferr_a !== 1'b1 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL frame_err: got f%0b v%0b b%0b, expected f1 v0 b0", ferr_a, valid_a, busy_a);
        end
        idle_cycles(1);
        checks++;
        if (ferr_a !== 1'b0 || valid_a !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_pulse: got f%0b v%0b, expected f0 v0", ferr_a, valid_a);
        end
    endtask

    task automatic test_overrun;
        int va;
        sb_a.push_back('{16'h003C, 1'b0});
        send_frame(1'b0, 16'h003C, 8, good_par(16'h003C, 0), STOP_BIT, 1, 1'b0, va);
        send_frame(1'b0, 16'h000F, 8, good_par(16'h000F, 0), STOP_BIT, 1, 1'b0, va);
        checks++;
        if (ovr_a !== 1'b1 || data_a !== 8'h3C || valid_a !== 1'b1) begin
            errors++;
            $display("FAIL overrun: got o%0b d%0h v%0b, expected o1 d3c v1", ovr_a, data_a, valid_a);
        end
        idle_cycles(1);
        checks++;
        if (ovr_a !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pulse: got o%0b, expected o0", ovr_a);
        end
        consume(1'b0);
        sb_a.push_back('{16'h003C, 1'b0});
        send_frame(1'b0, 16'h003C, 8, good_par(16'h003C, 0), STOP_BIT, 1, 1'b0, va);
        sb_a.push_back('{16'h000F, 1'b0});
        send_frame(1'b0, 16'h000F, 8, good_par(16'h000F, 0), STOP_BIT, 1, 1'b1, va);
        checks++;
        if (ovr_a !== 1'b0 || data_a !== 8'h0F || valid_a !== 1'b1) begin
            errors++;
            $display("FAIL drain_at_stop: got o%0b d%0h v%0b, expected o0 d0f v1", ovr_a, data_a, valid_a);
        end
        @(posedge clk); #1;
        set_ready(1'b0, 1'b0);
        checks++;
        if (valid_a !== 1'b0) begin
            errors++;
            $display("FAIL drain_final: got v%0b, expected v0", valid_a);
        end
    endtask

    task automatic test_reset_mid;
        int va;
        sb_a.push_back('{16'h0066, 1'b0});
        send_frame(1'b0, 16'h0066, 8, good_par(16'h0066, 0), STOP_BIT, 1, 1'b0, va);
        strobe(1'b0, START_BIT);
        repeat (4) strobe(1'b0, 1'b1);
        checks++;
        if (busy_a !== 1'b1 || valid_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame_busy: got b%0b v%0b, expected b1 v1", busy_a, valid_a);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({data_a, valid_a, perr_a, ferr_a, ovr_a, busy_a} !== 13'h0) begin
            errors++;
            $display("FAIL async_reset: got %0h, expected 0",
                     {data_a, valid_a, perr_a, ferr_a, ovr_a, busy_a});
        end
        sb_a.delete();
        din_a = LINE_IDLE;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(1);
        sb_a.push_back('{16'h0001, exp_perr(16'h0001, 1'b1, 1'b0)});
        send_frame(1'b0, 16'h0001, 8, 1'b1, STOP_BIT, 1, 1'b0, va);
        checks++;
        if (valid_a !== 1'b1 || data_a !== 8'h01 || perr_a !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: got v%0b d%0h p%0b, expected v1 d01 p0", valid_a, data_a, perr_a);
        end
        consume(1'b0);
    endtask

    task automatic test_slow_strobe;
        int va;
        sb_a.push_back('{16'h005A, 1'b0});
        send_frame(1'b0, 16'h005A, 8, good_par(16'h005A, 0), STOP_BIT, 4, 1'b0, va);
        checks++;
        if (va !== 11 || data_a !== 8'h5A || perr_a !== 1'b0) begin
            errors++;
            $display("FAIL slow_strobe: got strobe %0d d%0h p%0b, expected 11 d5a p0", va, data_a, perr_a);
        end
        consume(1'b0);
    endtask

    task automatic test_odd_w5;
        int va;
        sb_b.push_back('{16'h0013, exp_perr(16'h0013, 1'b0, 1'b1)});
        send_frame(1'b1, 16'h0013, 5, 1'b0, STOP_BIT, 1, 1'b0, va);
        checks++;
        if (va !== 8 || data_b !== 5'h13 || perr_b !== 1'b0) begin
            errors++;
            $display("FAIL odd_good: got strobe %0d d%0h p%0b, expected 8 d13 p0", va, data_b, perr_b);
        end
        consume(1'b1);
        sb_b.push_back('{16'h0013, exp_perr(16'h0013, 1'b1, 1'b1)});
        send_frame(1'b1, 16'h0013, 5, 1'b1, STOP_BIT, 1, 1'b0, va);
        checks++;
        if (data_b !== 5'h13 || perr_b !== 1'b1) begin
            errors++;
            $display("FAIL odd_bad: got d%0h p%0b, expected d13 p1", data_b, perr_b);
        end
        consume(1'b1);
    endtask

    task automatic test_back_to_back;
        int          va;
        logic [15:0] w;
        logic        par;
        set_ready(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            w   = 16'($urandom_range(0, 255));
            par = good_par(w, 0) ^ (i == 3);
            sb_a.push_back('{w, exp_perr(w, par, 1'b0)});
            send_frame(1'b0, w, 8, par, STOP_BIT, 1, 1'b0, va);
        end
        idle_cycles(2);
        set_ready(1'b0, 1'b0);
        checks++;
        if (valid_a !== 1'b0 || ovr_a !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: got v%0b o%0b, expected v0 o0", valid_a, ovr_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_overrun();
        test_reset_mid();
        test_slow_strobe();
        test_odd_w5();
        test_back_to_back();
        idle_cycles(2);
        checks++;
        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", sb_a.size(), sb_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
